// File: rtl/hall_input_filter_if.sv
// rtl/hall_input_filter_if.sv - Hall filter sensor/status bundle
interface hall_input_filter_if;
  logic [2:0] hall_in;
  logic       fault_clear;
  logic [2:0] hall_out;
  logic       hall_valid;
  logic       hall_change;
  logic       fault_invalid;
  logic       fault_skip;
  logic [7:0] skip_count;

  // Driver side: stimulus or upstream pin logic
  modport master (
    output hall_in, fault_clear,
    input  hall_out, hall_valid, hall_change, fault_invalid, fault_skip, skip_count
  );

  // Filter side
  modport slave (
    input  hall_in, fault_clear,
    output hall_out, hall_valid, hall_change, fault_invalid, fault_skip, skip_count
  );
endinterface

// File: rtl/hall_input_filter.sv
// rtl/hall_input_filter.sv - Hall sensor sync, glitch filter, fault flags (optional HALL_SKIP_DETECT_EN)
module hall_input_filter #(
  parameter int FILTER_CYCLES = 4,
  parameter int FILTER_WIDTH  = 4
) (
  input  logic               clk,
  input  logic               reset,
  hall_input_filter_if.slave bus
);

  localparam logic [FILTER_WIDTH-1:0] CNT_MAX = FILTER_WIDTH'(FILTER_CYCLES - 1);

  logic [2:0]              s1_q, s2_q;
  logic [2:0]              cand_q, cand_d;
  logic [FILTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]              hall_out_q, hall_out_d;
  logic                    valid_q, valid_d;
  logic                    change_q, change_d;
  logic                    finv_q, finv_d;
  logic                    inv_set;
  logic                    commit;
  logic                    legal;

  assign commit = (s2_q == cand_q) && (cnt_q == CNT_MAX);
  assign legal  = (cand_q != 3'b000) && (cand_q != 3'b111);

  // Candidate tracking: any change restarts the stability count
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Commit decode: legal codes update hall_out, illegal ones only drop valid
  always_comb begin
    hall_out_d = hall_out_q;
    valid_d    = valid_q;
    change_d   = 1'b0;
    inv_set    = 1'b0;
    if (commit) begin
      if (legal) begin
        change_d   = valid_q && (cand_q != hall_out_q);
        hall_out_d = cand_q;
        valid_d    = 1'b1;
      end else begin
        valid_d = 1'b0;
        inv_set = 1'b1;
      end
    end
    finv_d = inv_set | (finv_q & ~bus.fault_clear);
  end

  // Synchronizer, filter and committed-output state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q       <= 3'b000;
      s2_q       <= 3'b000;
      cand_q     <= 3'b000;
      cnt_q      <= '0;
      hall_out_q <= 3'b000;
      valid_q    <= 1'b0;
      change_q   <= 1'b0;
      finv_q     <= 1'b0;
    end else begin
      s1_q       <= bus.hall_in;
      s2_q       <= s1_q;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      hall_out_q <= hall_out_d;
      valid_q    <= valid_d;
      change_q   <= change_d;
      finv_q     <= finv_d;
    end
  end

  assign bus.hall_out      = hall_out_q;
  assign bus.hall_valid    = valid_q;
  assign bus.hall_change   = change_q;
  assign bus.fault_invalid = finv_q;

`ifdef HALL_SKIP_DETECT_EN
  logic       fskip_q, fskip_d;
  logic [7:0] skip_cnt_q, skip_cnt_d;
  logic       skip_set;

  // Position of a legal code in the commutation cycle 101,100,110,010,011,001
  function automatic logic [2:0] seq_pos(input logic [2:0] code);
    case (code)
      3'b101:  return 3'd0;
      3'b100:  return 3'd1;
      3'b110:  return 3'd2;
      3'b010:  return 3'd3;
      3'b011:  return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  function automatic logic [2:0] pos_next(input logic [2:0] pos);
    return (pos == 3'd5) ? 3'd0 : pos + 3'd1;
  endfunction

  // A strobed transition is a skip unless the codes are neighbours either way
  always_comb begin
    skip_set = change_d &&
               (pos_next(seq_pos(hall_out_q)) != seq_pos(cand_q)) &&
               (pos_next(seq_pos(cand_q)) != seq_pos(hall_out_q));
    fskip_d  = skip_set | (fskip_q & ~bus.fault_clear);
    if (skip_set) begin
      if (bus.fault_clear)          skip_cnt_d = 8'd1;
      else if (skip_cnt_q == 8'hff) skip_cnt_d = skip_cnt_q;
      else                          skip_cnt_d = skip_cnt_q + 8'd1;
    end else begin
      skip_cnt_d = bus.fault_clear ? 8'd0 : skip_cnt_q;
    end
  end

  // Sticky skip flag and saturating skip counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fskip_q    <= 1'b0;
      skip_cnt_q <= 8'd0;
    end else begin
      fskip_q    <= fskip_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign bus.fault_skip = fskip_q;
  assign bus.skip_count = skip_cnt_q;
`else
  assign bus.fault_skip = 1'b0;
  assign bus.skip_count = 8'd0;
`endif

endmodule

// File: doc/hall_input_filter.md
Name: hall_input_filter

Overview:
Conditions raw Hall-effect sensor inputs for one BLDC motor before they reach the Hall transition counter and commutation logic. Provides:
- A 2-FF synchronizer.
- A stability (glitch) filter.
- Rejection of illegal codes 000/111, with a sticky fault flag.
- A single-cycle change strobe.

Outputs feed the Hall counter `hall` input directly.

Parameters:
- FILTER_CYCLES, 4, consecutive synchronized cycles a code must hold before commit; legal range 1..2^FILTER_WIDTH-1.
- FILTER_WIDTH, 4, width of the stability counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- hall_in  input  3  raw, asynchronous Hall sensor pins {C,B,A}.
- fault_clear  input  1  synchronous single-cycle clear of sticky fault flags.
- hall_out  output  3  filtered, committed valid Hall code.
- hall_valid  output  1  high while hall_out reflects a currently stable legal code.
- hall_change  output  1  one-cycle strobe when hall_out changes between two legal codes.
- fault_invalid  output  1  sticky: an illegal code (000/111) was committed by the filter.
- fault_skip  output  1  sticky: committed transition skipped a step (see Optional Feature).
- skip_count  output  8  saturating count of skipped-step transitions (see Optional Feature).

Behaviour:
- Reset (async, active-high) values:
  - sync stages, candidate, hall_out = 000.
  - stability counter = 0.
  - hall_valid, hall_change, fault_invalid, fault_skip = 0.
  - skip_count = 0.
- Synchronizer: hall_in -> s1 -> s2, one flop each.
- Candidate/filter, each cycle:
  - If s2 != cand: cand <= s2, cnt <= 0.
  - Else: cnt increments, saturating at FILTER_CYCLES-1.
  - Commit condition: s2 == cand && cnt == FILTER_CYCLES-1. Evaluated every cycle; a commit of an unchanged value is a no-op.
- Latency: if hall_in changes before edge E0 and holds, commit occurs at edge E0+FILTER_CYCLES+2. With default 4, this is E0+6.
- Glitch rejection: any s2 change before the commit condition restarts the count. Pulses shorter than FILTER_CYCLES+1 synchronized cycles never reach hall_out.
- Commit of a legal code (101,100,110,010,011,001):
  - hall_out <= code; hall_valid <= 1.
  - hall_change <= 1 for exactly one cycle only if hall_valid was already 1 and code != hall_out.
  - First acquisition after reset or after an invalid period: no strobe.
- Commit of an illegal code (000 or 111):
  - hall_out holds its last legal value.
  - hall_valid <= 0; fault_invalid <= 1; no strobe.
- Sticky flags: fault_clear clears fault_invalid, fault_skip and skip_count. If a set event and fault_clear occur in the same cycle, the set wins (flag = 1; skip_count = 1).
- Reset mid-filter discards the pending candidate; filtering restarts from 000 with cnt 0.

Optional Feature:
Macro HALL_SKIP_DETECT_EN.
- Defined: on each legal-to-legal commit with hall_change asserted, compare old and new code in the cyclic sequence 101->100->110->010->011->001->101.
  - Non-adjacent in either direction: fault_skip <= 1 and skip_count increments, saturating at 255.
  - Adjacent: no effect.
- Undefined: fault_skip and skip_count are tied to 0; no comparison logic is synthesized.

Test Plan:
All scenarios use FILTER_CYCLES=4.
- Reset then hall_in=101 held -> hall_out=101 and hall_valid=1 at edge E0+6; hall_change stays 0 (first acquisition).
- Stable 101, then hall_in=100 held -> hall_out=100 at E0+6; hall_change=1 for exactly one cycle.
- Stable 100, then a 3-cycle glitch to 110 followed by return to 100 -> hall_out stays 100, no strobe, no fault.
- Stable 110, then hall_in=111 held -> hall_valid=0 at E0+6 with hall_out=110 and fault_invalid=1. Then hall_in=010 -> hall_valid=1, hall_out=010, no strobe. Then pulse fault_clear -> fault_invalid=0.
- With HALL_SKIP_DETECT_EN: 101 -> 110 committed -> fault_skip=1, skip_count=1. 300 alternating 101/110 skips -> skip_count=255. Without the macro: both remain 0.
- Assert reset asynchronously midway through a 100->110 filter window -> all outputs 0 immediately. After release with hall_in=110 held, commit occurs 6 edges later.
